// File: rtl/addsub_pkg.sv
// Shared types and constants for the sequential add/subtract unit.
// Holds the FSM encoding, the operation codes and a counter-width helper.
package addsub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // A single-slice configuration still needs a one-bit counter.
  function automatic int slice_cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_addsub_unit_if.sv
// Operand/result handshake bundle for seq_addsub_unit.
// master = operand source and result sink, slave = the arithmetic unit.
interface seq_addsub_unit_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic             sub;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             V;
  logic             Z;

  modport master (
    output in_valid, sub, A, B, Cin, out_ready,
    input  in_ready, out_valid, S, Cout, V, Z
  );

  modport slave (
    input  in_valid, sub, A, B, Cin, out_ready,
    output in_ready, out_valid, S, Cout, V, Z
  );
endinterface

// File: rtl/addsub_slice.sv
// SLICE-bit combinational ripple adder; zero latency, no flow control.
// cmsb exposes the carry into the slice MSB so the caller can derive signed overflow.
module addsub_slice #(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] s,
  output logic             cout,
  output logic             cmsb
);

  logic [SLICE:0] c;

  always_comb begin
    s    = '0;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < SLICE; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = c[SLICE];
  assign cmsb = c[SLICE-1];

endmodule

// File: rtl/seq_addsub_unit.sv
// Multi-cycle A+B+Cin / A-B-Cin engine, SLICE bits per cycle LSB first; out_valid N+1 edges after accept.
// out_ready low holds DONE and all results indefinitely; in_ready is high only in IDLE.
module seq_addsub_unit
  import addsub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  seq_addsub_unit_if.slave   bus
);

  localparam int             N    = WIDTH / SLICE;
  localparam int             CW   = slice_cnt_w(N);
  localparam logic [CW-1:0]  LAST = CW'(N - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [WIDTH-1:0] s_q;
  logic [WIDTH-1:0] s_nxt;
  logic             cout_q;
  logic             v_q;
  logic             z_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic [SLICE-1:0] sl_a;
  logic [SLICE-1:0] sl_b;
  logic [SLICE-1:0] sl_s;
  logic             sl_cout;
  logic             sl_cmsb;

  assign sl_a = a_q[cnt*SLICE +: SLICE];
  assign sl_b = b_q[cnt*SLICE +: SLICE];

  addsub_slice #(.SLICE(SLICE)) u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (carry_q),
    .s    (sl_s),
    .cout (sl_cout),
    .cmsb (sl_cmsb)
  );

  always_comb begin
    s_nxt                     = s_q;
    s_nxt[cnt*SLICE +: SLICE] = sl_s;
  end

  // Subtraction runs through the same adder as A + ~B + ~Cin, so Cout reads as NOT borrow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      s_q         <= '0;
      cout_q      <= 1'b0;
      v_q         <= 1'b0;
      z_q         <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            a_q        <= bus.A;
            b_q        <= (bus.sub == OP_ADD) ? bus.B : ~bus.B;
            carry_q    <= (bus.sub == OP_SUB) ? ~bus.Cin : bus.Cin;
            cnt        <= '0;
            in_ready_q <= 1'b0;
            state      <= ST_RUN;
          end
        end
        ST_RUN: begin
          s_q     <= s_nxt;
          carry_q <= sl_cout;
          cnt     <= cnt + 1'b1;
          if (cnt == LAST) begin
            cout_q <= sl_cout;
            v_q    <= sl_cmsb ^ sl_cout;
            cnt    <= '0;
            state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          // First DONE cycle settles Z from the completed sum before presenting it.
          if (!out_valid_q) begin
            z_q         <= (s_q == '0);
            out_valid_q <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.S         = s_q;
  assign bus.Cout      = cout_q;
  assign bus.V         = v_q;
  assign bus.Z         = z_q;

endmodule
